// File: rtl/axi_slv_port_mux.sv
// Merges NoSlvPorts AXI4 request bundles onto one master port: round-robin AW/AR with the input
// index prepended to the ID, W routed in AW-grant order, B/R returned by the ID prefix.
package axi_slv_port_mux_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } slv_ax_t;
    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } mst_ax_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } slv_b_t;
    typedef struct packed { logic [5:0] id; logic [1:0] resp; } mst_b_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } slv_r_t;
    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } mst_r_t;
    typedef struct packed {
        slv_ax_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        slv_ax_t ar; logic ar_valid; logic r_ready;
    } slv_req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        slv_b_t b; logic b_valid; slv_r_t r; logic r_valid;
    } slv_resp_t;
    typedef struct packed {
        mst_ax_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        mst_ax_t ar; logic ar_valid; logic r_ready;
    } mst_req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        mst_b_t b; logic b_valid; mst_r_t r; logic r_valid;
    } mst_resp_t;
endpackage

module axi_slv_port_mux_chk #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned PfxW       = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            b_valid_i,
    input logic [PfxW-1:0] b_pfx_i,
    input logic            r_valid_i,
    input logic [PfxW-1:0] r_pfx_i
);
    a_b_pfx: assert property (@(posedge clk_i) disable iff (rst_i)
        b_valid_i |-> (32'(b_pfx_i) < NoSlvPorts));
    a_r_pfx: assert property (@(posedge clk_i) disable iff (rst_i)
        r_valid_i |-> (32'(r_pfx_i) < NoSlvPorts));
endmodule

module axi_slv_port_mux #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned SlvIdWidth = 4,
    parameter int unsigned MaxWTrans  = 8,
    parameter type slv_req_t  = axi_slv_port_mux_pkg::slv_req_t,
    parameter type slv_resp_t = axi_slv_port_mux_pkg::slv_resp_t,
    parameter type mst_req_t  = axi_slv_port_mux_pkg::mst_req_t,
    parameter type mst_resp_t = axi_slv_port_mux_pkg::mst_resp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  slv_req_t  [NoSlvPorts-1:0] slv_reqs_i,
    output slv_resp_t [NoSlvPorts-1:0] slv_resps_o,
    output mst_req_t                   mst_req_o,
    input  mst_resp_t                  mst_resp_i
);
    localparam int unsigned PfxW  = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1;
    localparam int unsigned FPtrW = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
    localparam int unsigned FCntW = $clog2(MaxWTrans + 1);
    typedef logic [PfxW-1:0]  idx_t;
    typedef logic [FPtrW-1:0] fptr_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HOLD = 1'b1} arb_state_e;

    // First requester at or after ptr in circular order.
    function automatic idx_t rr_pick(input logic [NoSlvPorts-1:0] req, input idx_t ptr);
        idx_t        pick;
        idx_t        cand;
        pick = ptr;
        for (int unsigned k = NoSlvPorts; k > 0; k--) begin
            cand = idx_t'((32'(ptr) + k - 32'd1) % NoSlvPorts);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    function automatic idx_t idx_inc(input idx_t i);
        return (32'(i) == NoSlvPorts - 32'd1) ? idx_t'(0) : i + idx_t'(1);
    endfunction

    function automatic fptr_t fptr_inc(input fptr_t p);
        return (32'(p) == MaxWTrans - 32'd1) ? fptr_t'(0) : p + fptr_t'(1);
    endfunction

    arb_state_e            aw_state_q, ar_state_q;
    idx_t                  aw_sel_q, aw_ptr_q, ar_sel_q, ar_ptr_q;
    idx_t                  fifo_q [MaxWTrans];
    fptr_t                 wr_q, rd_q;
    logic [FCntW-1:0]      cnt_q;

    logic                  run_s, fifo_full_s, fifo_empty_s, push_s, pop_s;
    logic [NoSlvPorts-1:0] aw_req_s, ar_req_s;
    idx_t                  aw_win_s, ar_win_s, head_s, b_dest_s, r_dest_s;
    logic                  aw_valid_s, aw_hs_s, ar_valid_s, ar_hs_s, w_valid_s, w_hs_s;

    // Arbitration, FIFO status and handshake decode; reset masks every valid/ready.
    always_comb begin
        run_s        = !rst_i;
        fifo_full_s  = (cnt_q == FCntW'(MaxWTrans));
        fifo_empty_s = (cnt_q == FCntW'(0));
        for (int i = 0; i < NoSlvPorts; i++) begin
            aw_req_s[i] = slv_reqs_i[i].aw_valid;
            ar_req_s[i] = slv_reqs_i[i].ar_valid;
        end
        aw_win_s   = (aw_state_q == ST_HOLD) ? aw_sel_q : rr_pick(aw_req_s, aw_ptr_q);
        ar_win_s   = (ar_state_q == ST_HOLD) ? ar_sel_q : rr_pick(ar_req_s, ar_ptr_q);
        aw_valid_s = run_s && !fifo_full_s && ((aw_state_q == ST_HOLD) || (|aw_req_s));
        ar_valid_s = run_s && ((ar_state_q == ST_HOLD) || (|ar_req_s));
        aw_hs_s    = aw_valid_s && mst_resp_i.aw_ready;
        ar_hs_s    = ar_valid_s && mst_resp_i.ar_ready;
        head_s     = fifo_q[rd_q];
        w_valid_s  = run_s && !fifo_empty_s && slv_reqs_i[head_s].w_valid;
        w_hs_s     = w_valid_s && mst_resp_i.w_ready;
        push_s     = aw_hs_s;
        pop_s      = w_hs_s && slv_reqs_i[head_s].w.last;
        b_dest_s   = mst_resp_i.b.id[SlvIdWidth +: PfxW];
        r_dest_s   = mst_resp_i.r.id[SlvIdWidth +: PfxW];
    end

    // Channel muxing toward the master and demuxing of responses toward the inputs.
    always_comb begin
        mst_req_o         = '0;
        slv_resps_o       = '0;
        mst_req_o.aw.id   = {aw_win_s, slv_reqs_i[aw_win_s].aw.id};
        mst_req_o.aw.addr = slv_reqs_i[aw_win_s].aw.addr;
        mst_req_o.aw.len  = slv_reqs_i[aw_win_s].aw.len;
        mst_req_o.aw.atop = slv_reqs_i[aw_win_s].aw.atop;
        mst_req_o.aw_valid = aw_valid_s;
        mst_req_o.ar.id   = {ar_win_s, slv_reqs_i[ar_win_s].ar.id};
        mst_req_o.ar.addr = slv_reqs_i[ar_win_s].ar.addr;
        mst_req_o.ar.len  = slv_reqs_i[ar_win_s].ar.len;
        mst_req_o.ar.atop = slv_reqs_i[ar_win_s].ar.atop;
        mst_req_o.ar_valid = ar_valid_s;
        mst_req_o.w       = slv_reqs_i[head_s].w;
        mst_req_o.w_valid = w_valid_s;
        mst_req_o.b_ready = run_s && (32'(b_dest_s) < NoSlvPorts) && slv_reqs_i[b_dest_s].b_ready;
        mst_req_o.r_ready = run_s && (32'(r_dest_s) < NoSlvPorts) && slv_reqs_i[r_dest_s].r_ready;
        for (int i = 0; i < NoSlvPorts; i++) begin
            slv_resps_o[i].aw_ready = aw_hs_s && (aw_win_s == idx_t'(i));
            slv_resps_o[i].ar_ready = ar_hs_s && (ar_win_s == idx_t'(i));
            slv_resps_o[i].w_ready  = w_hs_s && (head_s == idx_t'(i));
            slv_resps_o[i].b.id     = mst_resp_i.b.id[SlvIdWidth-1:0];
            slv_resps_o[i].b.resp   = mst_resp_i.b.resp;
            slv_resps_o[i].b_valid  = run_s && mst_resp_i.b_valid && (b_dest_s == idx_t'(i));
            slv_resps_o[i].r.id     = mst_resp_i.r.id[SlvIdWidth-1:0];
            slv_resps_o[i].r.data   = mst_resp_i.r.data;
            slv_resps_o[i].r.resp   = mst_resp_i.r.resp;
            slv_resps_o[i].r.last   = mst_resp_i.r.last;
            slv_resps_o[i].r.user   = mst_resp_i.r.user;
            slv_resps_o[i].r_valid  = run_s && mst_resp_i.r_valid && (r_dest_s == idx_t'(i));
        end
    end

    // AW grant FSM: a stalled winner is latched so the payload stays on one input until ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_state_q <= ST_IDLE;
            aw_sel_q   <= idx_t'(0);
            aw_ptr_q   <= idx_t'(0);
        end else begin
            case (aw_state_q)
                ST_IDLE: if (aw_valid_s && !mst_resp_i.aw_ready) begin
                    aw_state_q <= ST_HOLD;
                    aw_sel_q   <= aw_win_s;
                end
                ST_HOLD: if (aw_hs_s) aw_state_q <= ST_IDLE;
                default: aw_state_q <= ST_IDLE;
            endcase
            if (aw_hs_s) aw_ptr_q <= idx_inc(aw_win_s);
        end
    end

    // AR grant FSM, same scheme as AW without the W-FIFO gate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_state_q <= ST_IDLE;
            ar_sel_q   <= idx_t'(0);
            ar_ptr_q   <= idx_t'(0);
        end else begin
            case (ar_state_q)
                ST_IDLE: if (ar_valid_s && !mst_resp_i.ar_ready) begin
                    ar_state_q <= ST_HOLD;
                    ar_sel_q   <= ar_win_s;
                end
                ST_HOLD: if (ar_hs_s) ar_state_q <= ST_IDLE;
                default: ar_state_q <= ST_IDLE;
            endcase
            if (ar_hs_s) ar_ptr_q <= idx_inc(ar_win_s);
        end
    end

    // W routing FIFO of AW winners; an entry retires with the last beat of its burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_q <= '{default: idx_t'(0)};
            wr_q   <= fptr_t'(0);
            rd_q   <= fptr_t'(0);
            cnt_q  <= FCntW'(0);
        end else begin
            if (push_s) begin
                fifo_q[wr_q] <= aw_win_s;
                wr_q         <= fptr_inc(wr_q);
            end
            if (pop_s) rd_q <= fptr_inc(rd_q);
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + FCntW'(1);
                2'b01:   cnt_q <= cnt_q - FCntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    axi_slv_port_mux_chk #(.NoSlvPorts(NoSlvPorts), .PfxW(PfxW)) u_chk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .b_valid_i (mst_resp_i.b_valid),
        .b_pfx_i   (b_dest_s),
        .r_valid_i (mst_resp_i.r_valid),
        .r_pfx_i   (r_dest_s)
    );
endmodule

// File: tb/tb_axi_slv_port_mux.sv
// Directed bench for axi_slv_port_mux: expected beats are queued at stimulus time and a negedge
// monitor compares every master-side AW/AR/W handshake and every slave-side B/R handshake.
module tb_axi_slv_port_mux;
    import axi_slv_port_mux_pkg::*;

    logic                 clk;
    logic                 rst;
    slv_req_t  [3:0]      slv_reqs;
    slv_resp_t [3:0]      slv_resps;
    mst_req_t             mst_req;
    mst_resp_t            mst_resp;
    logic [19:0]          slv_flags;
    logic [3:0]           slv_rvalid;

    int                   checks = 0;
    int                   errors = 0;
    logic [63:0]          exp_aw[$];
    logic [63:0]          exp_ar[$];
    logic [63:0]          exp_w[$];
    logic [63:0]          exp_b[$];
    logic [63:0]          exp_r[$];
    logic [63:0]          mon_e;

    axi_slv_port_mux #(.NoSlvPorts(4), .SlvIdWidth(4), .MaxWTrans(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv_reqs_i  (slv_reqs),
        .slv_resps_o (slv_resps),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slv_flags[i*5 +: 5] = {slv_resps[i].aw_ready, slv_resps[i].ar_ready,
                                   slv_resps[i].w_ready, slv_resps[i].b_valid,
                                   slv_resps[i].r_valid};
            slv_rvalid[i] = slv_resps[i].r_valid;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected beat %h", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ax(input logic [1:0] idx, input logic [3:0] id,
                                      input logic [31:0] addr);
        return 64'({idx, id, addr});
    endfunction

    function automatic logic [63:0] wb(input logic [31:0] data, input logic last);
        return 64'({last, data});
    endfunction

    // Scoreboard monitor: every handshake must match the head of its expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mst_req.aw_valid && mst_resp.aw_ready) begin
                if (exp_aw.size() == 0) unexpected("aw", 64'({mst_req.aw.id, mst_req.aw.addr}));
                else begin
                    mon_e = exp_aw.pop_front();
                    chk("aw_beat", 64'({mst_req.aw.id, mst_req.aw.addr}), mon_e);
                end
            end
            if (mst_req.ar_valid && mst_resp.ar_ready) begin
                if (exp_ar.size() == 0) unexpected("ar", 64'({mst_req.ar.id, mst_req.ar.addr}));
                else begin
                    mon_e = exp_ar.pop_front();
                    chk("ar_beat", 64'({mst_req.ar.id, mst_req.ar.addr}), mon_e);
                end
            end
            if (mst_req.w_valid && mst_resp.w_ready) begin
                if (exp_w.size() == 0) unexpected("w", 64'({mst_req.w.last, mst_req.w.data}));
                else begin
                    mon_e = exp_w.pop_front();
                    chk("w_beat", 64'({mst_req.w.last, mst_req.w.data}), mon_e);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (slv_resps[i].b_valid && slv_reqs[i].b_ready) begin
                    if (exp_b.size() == 0) unexpected("b", 64'(slv_resps[i].b));
                    else begin
                        mon_e = exp_b.pop_front();
                        chk("b_beat", 64'({2'(i), slv_resps[i].b.id, slv_resps[i].b.resp}), mon_e);
                    end
                end
                if (slv_resps[i].r_valid && slv_reqs[i].r_ready) begin
                    if (exp_r.size() == 0) unexpected("r", 64'(slv_resps[i].r));
                    else begin
                        mon_e = exp_r.pop_front();
                        chk("r_beat", 64'({2'(i), slv_resps[i].r.id, slv_resps[i].r.last,
                                           slv_resps[i].r.user, slv_resps[i].r.data}), mon_e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst      = 1'b1;
        slv_reqs = '0;
        mst_resp = '0;
        for (int i = 0; i < 4; i++) begin
            slv_reqs[i].aw_valid = 1'b1;
            slv_reqs[i].ar_valid = 1'b1;
            slv_reqs[i].w_valid  = 1'b1;
            slv_reqs[i].b_ready  = 1'b1;
            slv_reqs[i].r_ready  = 1'b1;
        end
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.b_valid  = 1'b1;
        mst_resp.r_valid  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mst", 64'({mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid,
                            mst_req.b_ready, mst_req.r_ready}), 64'd0);
        chk("rst_slv", 64'(slv_flags), 64'd0);
        slv_reqs = '0;
        mst_resp = '0;
        tick();
        rst = 1'b0;

        // Fairness: all four AWs valid, grants 0,1,2,3,0.
        mst_resp.aw_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            slv_reqs[i].aw_valid = 1'b1;
            slv_reqs[i].aw.id    = 4'(8 + i);
            slv_reqs[i].aw.addr  = 32'h1000 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            exp_aw.push_back(ax(2'(k % 4), 4'(8 + (k % 4)), 32'h1000 + 32'(k % 4)));
            tick();
        end
        for (int i = 0; i < 4; i++) slv_reqs[i].aw_valid = 1'b0;
        mst_resp.aw_ready = 1'b0;

        // Drain single-beat W bursts in grant order 0,1,2,3,0.
        mst_resp.w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            slv_reqs[i].w_valid = 1'b1;
            slv_reqs[i].w.last  = 1'b1;
            slv_reqs[i].w.data  = 32'hD0 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            exp_w.push_back(wb(32'hD0 + 32'(k % 4), 1'b1));
            tick();
        end
        for (int i = 0; i < 4; i++) slv_reqs[i].w_valid = 1'b0;

        // Stability: input 2 stalls for 5 cycles while input 1 raises valid.
        slv_reqs[2].aw_valid = 1'b1;
        slv_reqs[2].aw.id    = 4'h3;
        slv_reqs[2].aw.addr  = 32'h2222;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_payload", 64'({mst_req.aw_valid, mst_req.aw.id, mst_req.aw.addr}),
                64'({1'b1, 6'h23, 32'h2222}));
            tick();
            if (c == 0) begin
                slv_reqs[1].aw_valid = 1'b1;
                slv_reqs[1].aw.id    = 4'h7;
                slv_reqs[1].aw.addr  = 32'h1111;
            end
        end
        exp_aw.push_back(ax(2'd2, 4'h3, 32'h2222));
        mst_resp.aw_ready = 1'b1;
        tick();
        slv_reqs[2].aw_valid = 1'b0;
        exp_aw.push_back(ax(2'd1, 4'h7, 32'h1111));
        tick();
        slv_reqs[1].aw_valid = 1'b0;
        mst_resp.aw_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            slv_reqs[2 - k].w_valid = 1'b1;
            slv_reqs[2 - k].w.last  = 1'b1;
            slv_reqs[2 - k].w.data  = 32'hE0 + 32'(k);
            exp_w.push_back(wb(32'hE0 + 32'(k), 1'b1));
            tick();
            slv_reqs[2 - k].w_valid = 1'b0;
        end

        // W ordering: AW from 3 then 1; input 1 offers W first but waits for 3's burst.
        mst_resp.aw_ready    = 1'b1;
        slv_reqs[3].aw_valid = 1'b1;
        slv_reqs[3].aw.id    = 4'h9;
        slv_reqs[3].aw.addr  = 32'h3333;
        slv_reqs[3].w_valid  = 1'b1;
        slv_reqs[3].w.data   = 32'h30;
        slv_reqs[3].w.last   = 1'b0;
        exp_aw.push_back(ax(2'd3, 4'h9, 32'h3333));
        @(negedge clk);
        chk("w_no_bypass", 64'({mst_req.w_valid, slv_resps[3].w_ready}), 64'd0);
        tick();
        slv_reqs[3].aw_valid = 1'b0;
        slv_reqs[1].aw_valid = 1'b1;
        slv_reqs[1].aw.id    = 4'h4;
        slv_reqs[1].aw.addr  = 32'h1144;
        slv_reqs[1].w_valid  = 1'b1;
        slv_reqs[1].w.data   = 32'hB0;
        slv_reqs[1].w.last   = 1'b1;
        exp_aw.push_back(ax(2'd1, 4'h4, 32'h1144));
        for (int b = 0; b < 4; b++) begin
            slv_reqs[3].w.data = 32'h30 + 32'(b);
            slv_reqs[3].w.last = (b == 3);
            exp_w.push_back(wb(32'h30 + 32'(b), b == 3));
            @(negedge clk);
            chk("w_in1_blocked", 64'(slv_resps[1].w_ready), 64'd0);
            tick();
            if (b == 0) slv_reqs[1].aw_valid = 1'b0;
        end
        slv_reqs[3].w_valid = 1'b0;
        exp_w.push_back(wb(32'hB0, 1'b1));
        @(negedge clk);
        chk("w_in1_ready", 64'(slv_resps[1].w_ready), 64'd1);
        tick();
        slv_reqs[1].w_valid = 1'b0;

        // FIFO full: 8 AWs without W, the ninth waits for one W last.
        slv_reqs[0].aw_valid = 1'b1;
        slv_reqs[0].aw.id    = 4'h1;
        slv_reqs[0].aw.addr  = 32'h0F00;
        for (int k = 0; k < 8; k++) begin
            exp_aw.push_back(ax(2'd0, 4'h1, 32'h0F00));
            tick();
        end
        @(negedge clk);
        chk("full_blocks_aw", 64'({mst_req.aw_valid, slv_resps[0].aw_ready}), 64'd0);
        tick();
        slv_reqs[0].w_valid = 1'b1;
        slv_reqs[0].w.last  = 1'b1;
        slv_reqs[0].w.data  = 32'hF0;
        exp_w.push_back(wb(32'hF0, 1'b1));
        @(negedge clk);
        chk("full_pop_cycle", 64'(slv_resps[0].aw_ready), 64'd0);
        tick();
        slv_reqs[0].w_valid = 1'b0;
        exp_aw.push_back(ax(2'd0, 4'h1, 32'h0F00));
        @(negedge clk);
        chk("aw_after_pop", 64'(slv_resps[0].aw_ready), 64'd1);
        tick();
        slv_reqs[0].aw_valid = 1'b0;
        mst_resp.aw_ready    = 1'b0;
        slv_reqs[0].w_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            slv_reqs[0].w.data = 32'hF1 + 32'(k);
            exp_w.push_back(wb(32'hF1 + 32'(k), 1'b1));
            tick();
        end
        slv_reqs[0].w_valid = 1'b0;

        // AR round-robin: inputs 1 and 3 -> grants 1 then 3.
        mst_resp.ar_ready    = 1'b1;
        slv_reqs[1].ar_valid = 1'b1;
        slv_reqs[1].ar.id    = 4'h2;
        slv_reqs[1].ar.addr  = 32'hA1;
        slv_reqs[3].ar_valid = 1'b1;
        slv_reqs[3].ar.id    = 4'h6;
        slv_reqs[3].ar.addr  = 32'hA3;
        exp_ar.push_back(ax(2'd1, 4'h2, 32'hA1));
        tick();
        exp_ar.push_back(ax(2'd3, 4'h6, 32'hA3));
        tick();
        slv_reqs[1].ar_valid = 1'b0;
        slv_reqs[3].ar_valid = 1'b0;

        // B return to input 3, R return to input 2 with backpressure.
        mst_resp.b_valid    = 1'b1;
        mst_resp.b.id       = 6'h3A;
        mst_resp.b.resp     = 2'b10;
        slv_reqs[3].b_ready = 1'b1;
        exp_b.push_back(64'({2'd3, 4'hA, 2'b10}));
        @(negedge clk);
        chk("b_ready_path", 64'(mst_req.b_ready), 64'd1);
        tick();
        mst_resp.b_valid    = 1'b0;
        slv_reqs[3].b_ready = 1'b0;
        mst_resp.r_valid    = 1'b1;
        mst_resp.r.id       = 6'h25;
        mst_resp.r.data     = 32'hCAFE;
        mst_resp.r.last     = 1'b1;
        mst_resp.r.user     = 1'b1;
        @(negedge clk);
        chk("r_dest_only", 64'(slv_rvalid), 64'h4);
        chk("r_id_strip", 64'(slv_resps[2].r.id), 64'h5);
        chk("r_ready_low", 64'(mst_req.r_ready), 64'd0);
        tick();
        slv_reqs[2].r_ready = 1'b1;
        exp_r.push_back(64'({2'd2, 4'h5, 1'b1, 1'b1, 32'hCAFE}));
        @(negedge clk);
        chk("r_ready_high", 64'(mst_req.r_ready), 64'd1);
        tick();
        mst_resp.r_valid    = 1'b0;
        slv_reqs[2].r_ready = 1'b0;
        tick();

        chk("left_aw", 64'(exp_aw.size()), 64'd0);
        chk("left_ar", 64'(exp_ar.size()), 64'd0);
        chk("left_w", 64'(exp_w.size()), 64'd0);
        chk("left_br", 64'(exp_b.size() + exp_r.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
